// File: rtl/pixel_stream_packer_if.sv
// Pixel stream bus between a camera source and pixel_stream_packer.
// Handshake: a pixel moves on a rising clk edge where in_valid=1 and in_ready=1;
// the source holds in_rgb/in_sof stable with in_valid, and the sink may drop in_ready at any time.
interface pixel_stream_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [23:0] in_rgb;
    logic [30:0] OUTDATA;
    logic        frame_done;

    modport master (
        output in_valid,
        output in_sof,
        output in_rgb,
        input  in_ready,
        input  OUTDATA,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_rgb,
        output in_ready,
        output OUTDATA,
        output frame_done
    );
endinterface

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: accepts one RGB pixel at a time, computes its luma and
// presents {luma, x, y} on OUTDATA, followed by a strobe phase.
// Raster counters track the pixel position; in_sof restarts them at (0,0).
// Optional macro CAPTURE_WINDOW_ONLY_EN: only pixels inside x 208..431,
// y 128..351 are emitted; others just advance the counters.
module pixel_stream_packer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int HALF_PERIOD = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    pixel_stream_packer_if.slave   bus,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SETUP = 2'd2,
        HIGH  = 2'd3
    } state_t;

    localparam int             CW         = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0]  PHASE_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [10:0]    X_LAST     = 11'(H_ACTIVE - 1);
    localparam logic [10:0]    Y_LAST     = 11'(V_ACTIVE - 1);

    state_t          state;
    logic [CW-1:0]   phase_cnt;
    logic            ready_q;
    logic            strobe_q;
    logic            done_q;
    logic [29:0]     data_q;
    logic [7:0]      r_q;
    logic [7:0]      g_q;
    logic [7:0]      b_q;
    logic [10:0]     pix_x_q;
    logic [10:0]     pix_y_q;
    logic [10:0]     next_x;
    logic [10:0]     next_y;

    logic            accept;
    logic [10:0]     cur_x;
    logic [10:0]     cur_y;
    logic            at_x_last;
    logic            at_y_last;
    logic            in_window;
    logic [15:0]     luma_sum;
    logic [7:0]      luma;

    // Coordinates the arriving pixel would get; in_sof forces (0,0).
    always_comb begin
        accept    = bus.in_valid & ready_q;
        cur_x     = bus.in_sof ? 11'd0 : next_x;
        cur_y     = bus.in_sof ? 11'd0 : next_y;
        at_x_last = (cur_x == X_LAST);
        at_y_last = (cur_y == Y_LAST);
`ifdef CAPTURE_WINDOW_ONLY_EN
        in_window = (cur_x >= 11'd208) && (cur_x <= 11'd431) &&
                    (cur_y >= 11'd128) && (cur_y <= 11'd351);
`else
        in_window = 1'b1;
`endif
    end

    // Weighted sum 77/150/29 with rounding; the weights sum to 256 so the result fits 8 bits.
    always_comb begin
        luma_sum = 16'd77 * 16'(r_q) + 16'd150 * 16'(g_q) + 16'd29 * 16'(b_q) + 16'd128;
        luma     = 8'(luma_sum >> 8);
    end

    // Control FSM plus raster counters; every output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            ready_q   <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            next_x    <= '0;
            next_y    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        next_x <= at_x_last ? 11'd0 : cur_x + 11'd1;
                        next_y <= at_x_last ? (at_y_last ? 11'd0 : cur_y + 11'd1) : cur_y;
                        done_q <= at_x_last & at_y_last;
                        if (in_window) begin
                            r_q     <= bus.in_rgb[23:16];
                            g_q     <= bus.in_rgb[15:8];
                            b_q     <= bus.in_rgb[7:0];
                            pix_x_q <= cur_x;
                            pix_y_q <= cur_y;
                            ready_q <= 1'b0;
                            state   <= CALC;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    data_q    <= {luma, pix_x_q, pix_y_q};
                    phase_cnt <= '0;
                    state     <= SETUP;
                end
                SETUP: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        strobe_q  <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        strobe_q  <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.OUTDATA    = {strobe_q, data_q};
    assign bus.frame_done = done_q;
    assign dbg_state      = state;

endmodule
